// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: steps through a fixed note table per effect, driving a divider frequency and gate.
// Optional build macro SFX_LOOP_EN: i_hold at the last-step expiry restarts the effect instead of finishing.
module sfx_sequencer #(
  parameter int          CLK_FREQ  = 12000000,
  parameter logic [31:0] IDLE_FREQ = 32'd1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_trig,
  input  logic [1:0]  i_sel,
  input  logic        i_hold,
  output logic [31:0] o_freq,
  output logic        o_gate,
  output logic        o_active,
  output logic        o_done
);

  localparam int PRESC = CLK_FREQ / 1000;
  localparam int PW    = $clog2(PRESC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

  typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;

  typedef struct packed {
    logic [31:0] freq;
    logic [7:0]  dur;
  } note_t;

  // freq 0 marks a rest; unused slots are never reached because is_last stops the walk
  function automatic note_t note_rom(input logic [1:0] sel, input logic [2:0] step);
    note_t n;
    n = '{freq: 32'd0, dur: 8'd1};
    case ({sel, step})
      5'b00_000: n = '{freq: 32'd1760, dur: 8'd20};
      5'b00_001: n = '{freq: 32'd1320, dur: 8'd20};
      5'b00_010: n = '{freq: 32'd880,  dur: 8'd20};
      5'b01_000: n = '{freq: 32'd110,  dur: 8'd50};
      5'b01_001: n = '{freq: 32'd0,    dur: 8'd20};
      5'b01_010: n = '{freq: 32'd98,   dur: 8'd50};
      5'b01_011: n = '{freq: 32'd82,   dur: 8'd80};
      5'b10_000: n = '{freq: 32'd55,   dur: 8'd60};
      5'b11_000: n = '{freq: 32'd440,  dur: 8'd30};
      5'b11_001: n = '{freq: 32'd494,  dur: 8'd30};
      5'b11_010: n = '{freq: 32'd523,  dur: 8'd30};
      5'b11_011: n = '{freq: 32'd494,  dur: 8'd30};
      default:   n = '{freq: 32'd0,    dur: 8'd1};
    endcase
    return n;
  endfunction

  function automatic logic is_last(input logic [1:0] sel, input logic [2:0] step);
    case (sel)
      2'd0:    return step >= 3'd2;
      2'd1:    return step >= 3'd3;
      2'd2:    return 1'b1;
      default: return step >= 3'd3;
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_sel, w_sel_nxt;
  logic [2:0]  r_step, w_step_nxt;
  logic [PW-1:0] r_presc;
  logic [7:0]  r_ms;
  logic [31:0] r_freq;
  logic        r_gate, r_active, r_done;
  logic        w_load, w_tick, w_expire, w_loop;
  note_t       w_nxt;

`ifdef SFX_LOOP_EN
  assign w_loop = i_hold;
`else
  assign w_loop = 1'b0 & i_hold;
`endif

  assign w_tick   = (r_presc == PRESC_MAX);
  assign w_expire = w_tick && (r_ms == 8'd1);
  assign w_nxt    = note_rom(w_sel_nxt, w_step_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_step_nxt  = r_step;
    w_load      = 1'b0;
    case (r_state)
      PLAY: begin
        if (i_trig) begin
          w_sel_nxt  = i_sel;
          w_step_nxt = 3'd0;
          w_load     = 1'b1;
        end else if (w_expire) begin
          if (!is_last(r_sel, r_step)) begin
            w_step_nxt = r_step + 3'd1;
            w_load     = 1'b1;
          end else if (w_loop) begin
            w_step_nxt = 3'd0;
            w_load     = 1'b1;
          end else begin
            w_state_nxt = FINISH;
          end
        end
      end
      default: begin
        // FINISH accepts a trigger exactly like IDLE; its o_done pulse is still emitted
        if (i_trig) begin
          w_state_nxt = PLAY;
          w_sel_nxt   = i_sel;
          w_step_nxt  = 3'd0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_sel    <= 2'd0;
      r_step   <= 3'd0;
      r_presc  <= '0;
      r_ms     <= 8'd0;
      r_freq   <= IDLE_FREQ;
      r_gate   <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_step   <= w_step_nxt;
      r_active <= (w_state_nxt == PLAY);
      r_done   <= (w_state_nxt == FINISH);
      if (w_load) begin
        r_presc <= '0;
        r_ms    <= w_nxt.dur;
        r_gate  <= (w_nxt.freq != 32'd0);
        if (w_nxt.freq != 32'd0) r_freq <= w_nxt.freq;
      end else if (r_state == PLAY && w_state_nxt == PLAY) begin
        if (w_tick) begin
          r_presc <= '0;
          r_ms    <= r_ms - 8'd1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end else begin
        r_presc <= '0;
        r_ms    <= 8'd0;
        r_gate  <= 1'b0;
      end
    end
  end

  assign o_freq   = r_freq;
  assign o_gate   = r_gate;
  assign o_active = r_active;
  assign o_done   = r_done;

endmodule
